mdio_controller: RTL and testbench

Sequencer and round-robin arbiter in front of `generador_mdio`.
- Accepts register read/write requests from `N_REQ` independent requesters and builds the 32-bit management frame.
- Drives the generator's start strobe, waits for the frame to complete, and returns read data, or a timeout error, to the granted requester.
- Only one frame is in flight at a time.

---
 rtl/mdio_pkg.sv | 27 ++
 rtl/mdio_controller_if.sv | 31 +++
 rtl/mdio_rr_arbiter.sv | 47 ++++
 rtl/mdio_controller.sv | 145 ++++++++++++++
 tb/tb_mdio_controller.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared types, frame constants and default timing for the MDIO request sequencer.
package mdio_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StBusy,
        StResp
    } state_e;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] TA    = 2'b10;

    localparam int unsigned DEF_START_HOLD     = 4;
    localparam int unsigned DEF_FRAME_CYCLES   = 128;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

    function automatic logic [31:0] build_frame(input logic        write,
                                                input logic [4:0]  phy,
                                                input logic [4:0]  regad,
                                                input logic [15:0] wdata);
        return {ST, (write ? OP_WR : OP_RD), phy, regad, TA, (write ? wdata : 16'h0000)};
    endfunction

endpackage

// File: rtl/mdio_controller_if.sv
// Request/response and generator-side signal bundle of the MDIO controller.
interface mdio_controller_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_write;
    logic [5*N_REQ-1:0]  req_phy;
    logic [5*N_REQ-1:0]  req_reg;
    logic [16*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    resp_valid;
    logic [15:0]         resp_rdata;
    logic                resp_err;
    logic                busy;
    logic                mdio_start;
    logic [31:0]         t_data;
    logic [15:0]         rd_data;
    logic                data_rdy;

    // Environment side: requesters plus the frame generator.
    modport master (
        output req_valid, req_write, req_phy, req_reg, req_wdata, rd_data, data_rdy,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy, mdio_start, t_data
    );

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_phy, req_reg, req_wdata, rd_data, data_rdy,
        output req_ready, resp_valid, resp_rdata, resp_err, busy, mdio_start, t_data
    );
endinterface

// File: rtl/mdio_rr_arbiter.sv
// Round-robin one-hot arbiter; the search starts just after the last granted requester.
module mdio_rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic                     accept,
    output logic [N_REQ-1:0]         grant_oh,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);
    localparam int unsigned IdxW = $clog2(N_REQ);

    logic [IdxW-1:0] last_grant_q;
    logic [IdxW-1:0] cand;
    logic            found;
    int unsigned     sum;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        sum       = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            sum = int'(last_grant_q) + off;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = sum[IdxW-1:0];
            if (!found && req_valid[cand]) begin
                found          = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= IdxW'(N_REQ - 1);
        end else if (accept) begin
            last_grant_q <= grant_idx;
        end
    end

endmodule

// File: rtl/mdio_controller.sv
// Arbitrates MDIO register requests, sequences one management frame at a time through the
// generator and returns read data or a timeout error to the granted requester.
module mdio_controller
    import mdio_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned START_HOLD     = DEF_START_HOLD,
    parameter int unsigned FRAME_CYCLES   = DEF_FRAME_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic         clk,
    input logic         reset,
    mdio_controller_if.slave bus
);
    localparam int unsigned IdxW = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]  grant_q;
    logic             write_q;
    logic [31:0]      t_data_q;
    logic [15:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [N_REQ-1:0] req_ready_q;
    logic [N_REQ-1:0] resp_oh;
    logic             accept;

    logic [N_REQ-1:0] grant_oh;
    logic [IdxW-1:0]  grant_idx;
    logic             sel_write;
    logic [4:0]       sel_phy, sel_reg;
    logic [15:0]      sel_wdata;

    mdio_rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .req_valid(bus.req_valid),
        .accept   (accept),
        .grant_oh (grant_oh),
        .grant_idx(grant_idx)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_phy   = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_write = bus.req_write[i];
                sel_phy   = bus.req_phy[5*i +: 5];
                sel_reg   = bus.req_reg[5*i +: 5];
                sel_wdata = bus.req_wdata[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        // Counter saturates so a stalled frame can never alias back into a valid count.
        cnt_d   = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
        unique case (state_q)
            StIdle: begin
                cnt_d = cnt_q;
                if (|bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == 9'(START_HOLD - 1)) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (write_q) begin
                    if (cnt_q == 9'(FRAME_CYCLES - 1)) begin
                        err_d   = 1'b0;
                        state_d = StResp;
                    end
                end else if (bus.data_rdy) begin
                    rdata_d = bus.rd_data;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == 9'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = 16'hFFFF;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                cnt_d   = cnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            grant_q     <= '0;
            write_q     <= 1'b0;
            t_data_q    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= accept ? grant_oh : '0;
            if (accept) begin
                grant_q  <= grant_idx;
                write_q  <= sel_write;
                t_data_q <= build_frame(sel_write, sel_phy, sel_reg, sel_wdata);
            end
        end
    end

    always_comb begin
        resp_oh = '0;
        if (state_q == StResp) begin
            resp_oh[grant_q] = 1'b1;
        end
    end

    // Outputs decode registered state only, so reset clears them asynchronously.
    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_oh;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.mdio_start = (state_q == StStart);
    assign bus.t_data     = t_data_q;

endmodule

// File: tb/tb_mdio_controller.sv
// Scoreboard bench for mdio_controller: expected responses are queued at stimulus time and
// compared when the controller accepts and completes each request.
module tb_mdio_controller;

    localparam int unsigned N_REQ          = 2;
    localparam int unsigned START_HOLD     = 4;
    localparam int unsigned FRAME_CYCLES   = 128;
    localparam int unsigned TIMEOUT_CYCLES = 256;

    typedef struct {
        int          idx;
        logic [31:0] frame;
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;

    mdio_controller_if #(.N_REQ(N_REQ)) bus ();

    mdio_controller #(
        .N_REQ         (N_REQ),
        .START_HOLD    (START_HOLD),
        .FRAME_CYCLES  (FRAME_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    int          acc_cnt = 0;
    int          resp_cnt = 0;
    int          start_seen = 0;
    logic        in_flight = 1'b0;
    logic [15:0] model_rdata = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_frame(input logic wr, input logic [4:0] p,
                                              input logic [4:0] r, input logic [15:0] d);
        return {2'b01, (wr ? 2'b01 : 2'b10), p, r, 2'b10, (wr ? d : 16'h0000)};
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            in_flight = 1'b0;
            exp_q.delete();
        end else begin
            if (|bus.req_ready) begin
                check_eq("overlap", 32'(in_flight), 32'd0);
                check_eq("busy_at_accept", 32'(bus.busy), 32'd1);
                if (exp_q.size() == 0) begin
                    check_eq("accept_unexpected", 32'(bus.req_ready), 32'd0);
                end else begin
                    check_eq("ready_onehot", 32'(bus.req_ready), 32'(1) << exp_q[0].idx);
                    check_eq("t_data", bus.t_data, exp_q[0].frame);
                end
                acc_cyc    = cyc;
                acc_cnt++;
                start_seen = 0;
                in_flight  = 1'b1;
            end
            if (bus.mdio_start) start_seen++;
            if (|bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("resp_unexpected", 32'(bus.resp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("resp_idx", 32'(bus.resp_valid), 32'(1) << e.idx);
                    check_eq("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    check_eq("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
                    check_eq("resp_err", 32'(bus.resp_err), 32'(e.err));
                    check_eq("start_cycles", 32'(start_seen), START_HOLD);
                    check_eq("t_data_held", bus.t_data, e.frame);
                end
                in_flight = 1'b0;
                resp_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int idx, input logic wr, input logic [4:0] p,
                            input logic [4:0] r, input logic [15:0] d,
                            input int rdy_at, input logic [15:0] rdval);
        exp_t e;
        e.idx   = idx;
        e.frame = exp_frame(wr, p, r, d);
        if (wr) begin
            e.rdata = model_rdata;
            e.err   = 1'b0;
            e.lat   = FRAME_CYCLES;
        end else if (rdy_at > 0) begin
            e.rdata = rdval;
            e.err   = 1'b0;
            e.lat   = rdy_at;
        end else begin
            e.rdata = 16'hFFFF;
            e.err   = 1'b1;
            e.lat   = TIMEOUT_CYCLES;
        end
        model_rdata = e.rdata;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [4:0] p,
                           input logic [4:0] r, input logic [15:0] d);
        bus.req_write[idx]         = wr;
        bus.req_phy[5*idx +: 5]    = p;
        bus.req_reg[5*idx +: 5]    = r;
        bus.req_wdata[16*idx +: 16] = d;
    endtask

    task automatic wait_accept(input int target);
        for (int k = 0; k < 50 && acc_cnt < target; k++) tick();
        check_eq("accept_seen", 32'(acc_cnt), 32'(target));
    endtask

    task automatic wait_resp(input int target, input int bound);
        for (int k = 0; k < bound && resp_cnt < target; k++) tick();
        check_eq("resp_seen", 32'(resp_cnt), 32'(target));
    endtask

    task automatic wait_until(input int rel);
        for (int k = 0; k < 400 && cyc < acc_cyc + rel; k++) tick();
    endtask

    task automatic pulse_rdy(input logic [15:0] val);
        bus.rd_data  = val;
        bus.data_rdy = 1'b1;
        tick();
        bus.data_rdy = 1'b0;
        bus.rd_data  = 16'h0BAD;
    endtask

    // One request; rdy_at > 0 raises data_rdy so it is sampled rdy_at edges after accept,
    // noise_at > 0 injects a stray data_rdy at that offset.
    task automatic issue(input int idx, input logic wr, input logic [4:0] p,
                         input logic [4:0] r, input logic [15:0] d,
                         input int rdy_at, input logic [15:0] rdval, input int noise_at);
        int a0, r0;
        a0 = acc_cnt;
        r0 = resp_cnt;
        push_exp(idx, wr, p, r, d, rdy_at, rdval);
        set_req(idx, wr, p, r, d);
        bus.req_valid[idx] = 1'b1;
        wait_accept(a0 + 1);
        bus.req_valid[idx] = 1'b0;
        if (noise_at > 0) begin
            wait_until(noise_at - 1);
            pulse_rdy(16'hDEAD);
        end
        if (!wr && rdy_at > 0) begin
            wait_until(rdy_at - 1);
            pulse_rdy(rdval);
        end
        wait_resp(r0 + 1, TIMEOUT_CYCLES + 50);
    endtask

    initial begin
        int r0, a0;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_phy   = '0;
        bus.req_reg   = '0;
        bus.req_wdata = '0;
        bus.rd_data   = 16'h0000;
        bus.data_rdy  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_start", 32'(bus.mdio_start), 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check_eq("rst_t_data", bus.t_data, 32'd0);
        check_eq("rst_rdata", 32'(bus.resp_rdata), 32'd0);

        // Stray data_rdy while idle must change nothing.
        pulse_rdy(16'hBEEF);
        tick();
        check_eq("idle_rdy_busy", 32'(bus.busy), 32'd0);
        check_eq("idle_rdy_rdata", 32'(bus.resp_rdata), 32'd0);

        issue(0, 1'b1, 5'h03, 5'h01, 16'hA5A5, 0, 16'h0, 0);
        tick();
        issue(1, 1'b0, 5'h1F, 5'h02, 16'h0000, 70, 16'h1234, 0);
        tick();
        issue(0, 1'b0, 5'h0A, 5'h1E, 16'h0000, 0, 16'h0, 0);
        tick();
        issue(1, 1'b1, 5'h11, 5'h07, 16'h5A3C, 0, 16'h0, 40);
        tick();

        // Both requesters hold valid: grants must alternate 0,1,0,1.
        r0 = resp_cnt;
        set_req(0, 1'b1, 5'h01, 5'h04, 16'h1111);
        set_req(1, 1'b1, 5'h02, 5'h05, 16'h2222);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_exp(0, 1'b1, 5'h01, 5'h04, 16'h1111, 0, 16'h0);
            else            push_exp(1, 1'b1, 5'h02, 5'h05, 16'h2222, 0, 16'h0);
        end
        bus.req_valid = 2'b11;
        wait_resp(r0 + 4, 4 * (FRAME_CYCLES + 10));
        bus.req_valid = 2'b00;
        tick();

        // Reset 50 cycles into a write: outputs drop at once, no response is issued.
        a0 = acc_cnt;
        push_exp(0, 1'b1, 5'h06, 5'h09, 16'hCAFE, 0, 16'h0);
        set_req(0, 1'b1, 5'h06, 5'h09, 16'hCAFE);
        bus.req_valid[0] = 1'b1;
        wait_accept(a0 + 1);
        bus.req_valid[0] = 1'b0;
        wait_until(50);
        #1 reset = 1'b1;
        #1;
        check_eq("abort_start", 32'(bus.mdio_start), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("abort_t_data", bus.t_data, 32'd0);
        r0 = resp_cnt;
        repeat (2) tick();
        reset       = 1'b0;
        model_rdata = 16'h0000;
        tick();
        check_eq("post_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_no_resp", 32'(resp_cnt), 32'(r0));

        // Both request after reset: requester 0 must win.
        a0 = acc_cnt;
        push_exp(0, 1'b1, 5'h0C, 5'h03, 16'h7E57, 0, 16'h0);
        set_req(0, 1'b1, 5'h0C, 5'h03, 16'h7E57);
        set_req(1, 1'b1, 5'h0D, 5'h03, 16'h0001);
        bus.req_valid = 2'b11;
        wait_accept(a0 + 1);
        bus.req_valid = 2'b00;
        wait_resp(r0 + 1, FRAME_CYCLES + 20);
        repeat (3) tick();
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
